// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The HALT state exists only when FETCH_HALT_EN is defined.
package fetch_unit_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned OPR_W = 5;
  localparam logic [7:0]  HALT_WORD = 8'h00;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2,
    HALT    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    PRESENT = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/fetch_unit.sv
// Three-phase instruction fetch: issue address, capture RAM word, present to execute.
// Optional halt-on-zero-word behaviour is enabled with FETCH_HALT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [OPR_W-1:0]  operand,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              halted
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc_out_d;
  logic [DATA_W-1:0] ir, ir_d;
  logic              ir_valid_d;
`ifdef FETCH_HALT_EN
  logic              halted_d;
`endif

  // The RAM address is the PC register itself, so it reads 0 during reset.
  assign ram_address = pc;
  assign ram_we      = 1'b0;
  assign opcode      = ir[OPC_W+OPR_W-1 -: OPC_W];
  assign operand     = ir[OPR_W-1:0];

  // Next-state and datapath decisions
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    pc_out_d   = pc_out;
    ir_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d   = 1'b0;
`endif

    case (state)
      ISSUE: begin
        if (!load_busy) state_d = CAPTURE;
      end
      CAPTURE: begin
        ir_d     = ram_data;
        pc_out_d = pc;
        pc_d     = pc + ADDR_W'(1);
`ifdef FETCH_HALT_EN
        if (ram_data == DATA_W'(HALT_WORD)) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          state_d    = PRESENT;
          ir_valid_d = 1'b1;
        end
`else
        state_d    = PRESENT;
        ir_valid_d = 1'b1;
`endif
      end
      PRESENT: begin
        if (ir_ready) state_d = ISSUE;
        else          ir_valid_d = 1'b1;
      end
`ifdef FETCH_HALT_EN
      HALT: begin
        halted_d = 1'b1;
      end
`endif
      default: state_d = ISSUE;
    endcase

    // Redirect wins over everything; an in-flight RAM word is simply not captured.
    if (jump) begin
      state_d    = ISSUE;
      pc_d       = jump_target;
      ir_d       = ir;
      pc_out_d   = pc_out;
      ir_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
      halted_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ISSUE;
      pc       <= '0;
      ir       <= '0;
      pc_out   <= '0;
      ir_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      halted   <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      pc_out   <= pc_out_d;
      ir_valid <= ir_valid_d;
`ifdef FETCH_HALT_EN
      halted   <= halted_d;
`endif
    end
  end

`ifndef FETCH_HALT_EN
  assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 5, width of the program counter and RAM address.
REQ-002 Parameter DATA_W, default 8, width of the instruction word.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 load_busy  in  1  RAM is being preloaded or written by another agent; fetch stalls while high.
REQ-006 ram_address  out  ADDR_W  read address presented to the RAM.
REQ-007 ram_we  out  1  RAM write enable; held 0 by this block.
REQ-008 ram_data  in  DATA_W  RAM registered read data, valid one cycle after the address is sampled.
REQ-009 ir_valid  out  1  instruction register holds an instruction for the execute stage.
REQ-010 ir_ready  in  1  execute stage accepts the instruction.
REQ-011 opcode  out  3  IR[7:5].
REQ-012 operand  out  5  IR[4:0].
REQ-013 pc_out  out  ADDR_W  address the presented instruction was fetched from.
REQ-014 jump  in  1  redirect request from the execute stage.
REQ-015 jump_target  in  ADDR_W  new PC, used when jump=1.
REQ-016 halted  out  1  halt detected (see Configuration).

Function
REQ-017 FSM states: ISSUE, CAPTURE, PRESENT, HALT.
REQ-018 ISSUE: ram_address=PC; go to CAPTURE next cycle unless load_busy=1, in which case stay in ISSUE.
REQ-019 CAPTURE: IR<=ram_data, pc_out<=PC, PC<=PC+1 (wraps 31->0), go to PRESENT.
REQ-020 PRESENT: ir_valid=1; IR, opcode, operand and pc_out stay stable until ir_valid&&ir_ready; on that handshake, go to ISSUE.
REQ-021 Fetch-to-valid latency from entering ISSUE is 2 cycles when load_busy=0.
REQ-022 Throughput is one instruction per 3 cycles when ir_ready is held high.
REQ-023 A jump in any state sets PC<=jump_target and state<=ISSUE; the next cycle ir_valid=0 and any in-flight RAM data is discarded.
REQ-024 If jump and a handshake occur in the same PRESENT cycle, the transfer counts and the PC takes jump_target (not PC+1).
REQ-025 load_busy rising during CAPTURE or PRESENT takes no effect until the next ISSUE.
REQ-026 ram_we is a constant 0 in every state.

Reset
REQ-027 While reset=1: PC=0, IR=0, pc_out=0, ir_valid=0, halted=0, ram_address=0, state=ISSUE, all asynchronously.
REQ-028 After reset is released, fetch starts from address 0 on the first edge with load_busy=0.
REQ-029 Reset asserted mid-fetch drops the in-flight instruction with no handshake.

Configuration
REQ-030 Macro FETCH_HALT_EN.
REQ-031 When it is defined, a CAPTURE of IR==0x00 goes to HALT instead of PRESENT, with halted=1 and ir_valid=0; HALT is left only by jump (to ISSUE, halted=0) or by reset.
REQ-032 When it is not defined, halted is tied to 0, there is no HALT state, and 0x00 is presented like any other instruction.

Structure
REQ-033 A shared package holds the FSM state enum, the OPC_W=3 and OPR_W=5 field widths, and the HALT_WORD=0x00 constant.
REQ-034 No sub-module; the PC incrementer and IR are inline.

Verification
REQ-035 RAM model preloaded with 0x80 at address 0 and 0x3E at address 1, ir_ready=1 -> ir_valid at cycles 2 and 5 with opcode=4/operand=0 and opcode=1/operand=30 respectively, and pc_out=0 then 1.
REQ-036 ir_ready=0 for 4 cycles in PRESENT -> IR stable, ram_address unchanged, no new fetch issued.
REQ-037 jump=1 with jump_target=7 while in CAPTURE -> next cycle ir_valid=0, ram_address=7, and the instruction from address 7 is presented next.
REQ-038 PC=31 fetched -> next ram_address=0 (wrap).
REQ-039 load_busy held high for 5 cycles after reset -> ram_address stays 0 and ir_valid stays 0; the first fetch happens after load_busy drops.
REQ-040 With FETCH_HALT_EN, address 30 holds 0x00 -> halted=1 and ir_valid=0 persist; a later jump to 0 clears halted and resumes fetch. Without the macro, the same word is presented as opcode=0, operand=0.
